// File: rtl/fir_multichannel_engine_pkg.sv
// Shared types, width helpers, result reduction functions and Q-format
// constants for the multichannel FIR engine.
package fir_multichannel_engine_pkg;

    // Engine sequencing: accept a sample, run the taps, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } firState_e;

    // Q8.8 helpers: fractional bit count and the fixed-point value of 1.0.
    localparam int Q_FRAC_BITS = 8;
    localparam int Q_ONE       = 1 << Q_FRAC_BITS;

    // Accumulator width that can hold NUM_TAPS full-width products.
    function automatic int accWidth(input int dataWidth, input int numTaps);
        return 2 * dataWidth + $clog2(numTaps);
    endfunction

    // Channel index width; always at least one bit.
    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

    // Clamp a wide signed value into the signed range of dataWidth bits.
    // The accumulator must fit in 64 bits for these helpers.
    function automatic logic signed [63:0] reduceSat(input logic signed [63:0] value,
                                                     input int dataWidth);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dataWidth - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Keep the low dataWidth bits (two's-complement wrap), sign-extended back.
    function automatic logic signed [63:0] reduceWrap(input logic signed [63:0] value,
                                                      input int dataWidth);
        logic signed [63:0] shiftedUp;
        shiftedUp = value <<< (64 - dataWidth);
        return shiftedUp >>> (64 - dataWidth);
    endfunction

endpackage

// File: rtl/fir_multichannel_engine_if.sv
// Sample-in and result-out handshake bundle of the multichannel FIR engine.
// master = sensor front end / result consumer side, slave = the engine.
interface fir_multichannel_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         inValid;
    logic                         inReady;
    logic [CH_W-1:0]              inChannel;
    logic signed [DATA_WIDTH-1:0] rawSensorVal;

    logic                         resultIsValid;
    logic                         resultReady;
    logic [CH_W-1:0]              resultChannel;
    logic signed [DATA_WIDTH-1:0] macResult;
    logic                         resultPrimed;

    modport master (
        output inValid, inChannel, rawSensorVal, resultReady,
        input  inReady, resultIsValid, resultChannel, macResult, resultPrimed
    );

    modport slave (
        input  inValid, inChannel, rawSensorVal, resultReady,
        output inReady, resultIsValid, resultChannel, macResult, resultPrimed
    );
endinterface

// File: rtl/fir_multichannel_engine_delay_line.sv
// Per-channel delay line: shift-in of the newest sample at tap 0, a tap-index
// read mux for the shared MAC, and a saturating fill counter telling whether
// every tap has held a real sample since the last clear.
module fir_multichannel_engine_delay_line #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          shiftEn,
    input  logic signed [DATA_WIDTH-1:0]  sampleIn,
    input  logic [$clog2(NUM_TAPS)-1:0]   tapIdx,
    output logic signed [DATA_WIDTH-1:0]  tapOut,
    output logic                          primed
);
    localparam int FILL_W = $clog2(NUM_TAPS + 1);

    logic signed [DATA_WIDTH-1:0] lineReg [NUM_TAPS];
    logic [FILL_W-1:0]            fillReg;

    // Shift register: newest sample enters at tap 0, oldest falls off the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) lineReg[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < NUM_TAPS; k++) lineReg[k] <= '0;
        end else if (shiftEn) begin
            lineReg[0] <= sampleIn;
            for (int k = 1; k < NUM_TAPS; k++) lineReg[k] <= lineReg[k-1];
        end
    end

    // Fill counter saturates at NUM_TAPS so it never wraps back to unprimed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fillReg <= '0;
        end else if (clr) begin
            fillReg <= '0;
        end else if (shiftEn && (fillReg != FILL_W'(NUM_TAPS))) begin
            fillReg <= fillReg + 1'b1;
        end
    end

    assign primed = (fillReg == FILL_W'(NUM_TAPS));
    assign tapOut = lineReg[tapIdx];

endmodule

// File: rtl/fir_multichannel_engine.sv
// Time-multiplexed multichannel FIR engine: one shared MAC walks the taps of
// the accepting channel's delay line against a shared coefficient bank.
// Optional macro FIR_SATURATE_EN: clamp the scaled result to the signed
// DATA_WIDTH range instead of wrapping to its low bits.
module fir_multichannel_engine
    import fir_multichannel_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = Q_FRAC_BITS,
    parameter int NUM_TAPS   = 8,
    parameter int NUM_CH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clrC,
    input  logic                          accelerateEn,
    input  logic                          coeffWriteEn,
    input  logic [$clog2(NUM_TAPS)-1:0]   coeffAddress,
    input  logic signed [DATA_WIDTH-1:0]  coeffIn,
    output logic                          coeffErr,
    output logic                          busy,
    fir_multichannel_engine_if.slave      bus
);
    localparam int TAP_W  = $clog2(NUM_TAPS);
    localparam int CH_W   = chWidth(NUM_CH);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = accWidth(DATA_WIDTH, NUM_TAPS);

    firState_e                    stateReg;
    logic [TAP_W-1:0]             tapCntReg;
    logic [CH_W-1:0]              activeChReg;
    logic signed [ACC_W-1:0]      accReg;
    logic signed [DATA_WIDTH-1:0] coeffBank [NUM_TAPS];
    logic                         resultValidReg;
    logic [CH_W-1:0]              resultChReg;
    logic signed [DATA_WIDTH-1:0] resultReg;
    logic                         resultPrimedReg;
    logic                         coeffErrReg;

    logic                         isIdle;
    logic                         acceptSample;
    logic                         channelInRange;
    logic                         lineClear;
    logic                         coeffWriteOk;
    logic signed [DATA_WIDTH-1:0] tapSample [NUM_CH];
    logic                         chPrimed  [NUM_CH];
    logic signed [DATA_WIDTH-1:0] curSample;
    logic signed [PROD_W-1:0]     product;
    logic signed [ACC_W-1:0]      accSum;
    logic signed [ACC_W-1:0]      accShift;
    logic signed [DATA_WIDTH-1:0] resultNext;

    assign isIdle         = (stateReg == IDLE);
    // clrC takes priority over a pending sample; nothing is offered during reset.
    assign bus.inReady    = isIdle & accelerateEn & ~clrC & ~rst;
    assign acceptSample   = bus.inValid & bus.inReady;
    // Out-of-range channels are consumed but leave no trace.
    assign channelInRange = (int'(bus.inChannel) < NUM_CH);
    assign lineClear      = isIdle & clrC;
    // Coefficients only change between samples so a running sum sees one set.
    assign coeffWriteOk   = isIdle & coeffWriteEn & (int'(coeffAddress) < NUM_TAPS);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_channel
            fir_multichannel_engine_delay_line #(
                .DATA_WIDTH (DATA_WIDTH),
                .NUM_TAPS   (NUM_TAPS)
            ) u_line (
                .clk      (clk),
                .rst      (rst),
                .clr      (lineClear),
                .shiftEn  (acceptSample & channelInRange & (bus.inChannel == CH_W'(gi))),
                .sampleIn (bus.rawSensorVal),
                .tapIdx   (tapCntReg),
                .tapOut   (tapSample[gi]),
                .primed   (chPrimed[gi])
            );
        end
    endgenerate

    assign curSample = tapSample[activeChReg];
    assign product   = PROD_W'(curSample) * PROD_W'(coeffBank[tapCntReg]);
    assign accSum    = accReg + ACC_W'(product);
    assign accShift  = accSum >>> FRAC_BITS;
`ifdef FIR_SATURATE_EN
    assign resultNext = DATA_WIDTH'(reduceSat(64'(accShift), DATA_WIDTH));
`else
    assign resultNext = DATA_WIDTH'(reduceWrap(64'(accShift), DATA_WIDTH));
`endif

    // Shared coefficient bank, written by the host while the engine is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) coeffBank[k] <= '0;
        end else if (coeffWriteOk) begin
            coeffBank[coeffAddress] <= coeffIn;
        end
    end

    // Engine FSM with MAC datapath and registered result/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg        <= IDLE;
            tapCntReg       <= '0;
            activeChReg     <= '0;
            accReg          <= '0;
            resultValidReg  <= 1'b0;
            resultChReg     <= '0;
            resultReg       <= '0;
            resultPrimedReg <= 1'b0;
            coeffErrReg     <= 1'b0;
        end else begin
            coeffErrReg <= coeffWriteEn & ~coeffWriteOk;
            case (stateReg)
                IDLE: begin
                    if (acceptSample && channelInRange) begin
                        activeChReg <= bus.inChannel;
                        accReg      <= '0;
                        tapCntReg   <= '0;
                        stateReg    <= MAC;
                    end
                end
                MAC: begin
                    accReg    <= accSum;
                    tapCntReg <= tapCntReg + 1'b1;
                    // Final tap: the sum including this product is the result.
                    if (tapCntReg == TAP_W'(NUM_TAPS - 1)) begin
                        resultReg       <= resultNext;
                        resultChReg     <= activeChReg;
                        resultPrimedReg <= chPrimed[activeChReg];
                        resultValidReg  <= 1'b1;
                        stateReg        <= OUT;
                    end
                end
                OUT: begin
                    if (bus.resultReady) begin
                        resultValidReg <= 1'b0;
                        stateReg       <= IDLE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign bus.resultIsValid = resultValidReg;
    assign bus.resultChannel = resultChReg;
    assign bus.macResult     = resultReg;
    assign bus.resultPrimed  = resultPrimedReg;
    assign coeffErr          = coeffErrReg;
    assign busy              = (stateReg != IDLE);

endmodule

// File: tb/tb_fir_multichannel_engine.sv
// Scoreboard bench for fir_multichannel_engine at default parameters (Q8.8,
// 8 taps, 2 channels). Expected results are pushed when a sample is issued;
// the monitor pops and compares whenever a result handshake completes.
`timescale 1ns/1ps
module tb_fir_multichannel_engine;
    import fir_multichannel_engine_pkg::*;

    localparam int DW = 16;
    localparam int NT = 8;
    localparam int NC = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clrC = 1'b0;
    logic               accelerateEn = 1'b1;
    logic               coeffWriteEn = 1'b0;
    logic [2:0]         coeffAddress = '0;
    logic signed [15:0] coeffIn = '0;
    logic               coeffErr;
    logic               busy;

    fir_multichannel_engine_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

    fir_multichannel_engine #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (Q_FRAC_BITS),
        .NUM_TAPS   (NT),
        .NUM_CH     (NC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clrC         (clrC),
        .accelerateEn (accelerateEn),
        .coeffWriteEn (coeffWriteEn),
        .coeffAddress (coeffAddress),
        .coeffIn      (coeffIn),
        .coeffErr     (coeffErr),
        .busy         (busy),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ch;
        logic [15:0] value;
        logic        primed;
    } exp_t;

    exp_t sbQueue[$];
    exp_t expItem;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic ch, input logic [15:0] value, input logic primed);
        sbQueue.push_back('{ch, value, primed});
    endtask

    task automatic sendSample(input logic ch, input logic [15:0] value);
        int waitCnt;
        @(posedge clk); #1;
        bus.inValid      = 1'b1;
        bus.inChannel    = ch;
        bus.rawSensorVal = value;
        waitCnt = 0;
        forever begin
            @(negedge clk);
            if (bus.inReady || waitCnt > 200) break;
            waitCnt++;
        end
        check("accept_ready", 32'(bus.inReady), 32'd1);
        @(posedge clk); #1;
        bus.inValid = 1'b0;
    endtask

    task automatic writeCoeff(input logic [2:0] addr, input logic [15:0] value);
        @(posedge clk); #1;
        coeffWriteEn = 1'b1;
        coeffAddress = addr;
        coeffIn      = value;
        @(posedge clk); #1;
        coeffWriteEn = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sbQueue.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", 32'(sbQueue.size()), 32'd0);
    endtask

    // Monitor: every completed result handshake is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && bus.resultIsValid && bus.resultReady) begin
            if (sbQueue.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got ch=%0d value=0x%04h, required none",
                         bus.resultChannel, bus.macResult);
            end else begin
                expItem = sbQueue.pop_front();
                $display("RESULT ch=%0d value=0x%04h primed=%0d (expected ch=%0d value=0x%04h primed=%0d)",
                         bus.resultChannel, bus.macResult, bus.resultPrimed,
                         expItem.ch, expItem.value, expItem.primed);
                check("result_value", 32'($unsigned(bus.macResult)), 32'(expItem.value));
                check("result_channel", 32'(bus.resultChannel), 32'(expItem.ch));
                check("result_primed", 32'(bus.resultPrimed), 32'(expItem.primed));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [15:0] expVal;

        bus.inValid      = 1'b0;
        bus.inChannel    = '0;
        bus.rawSensorVal = '0;
        bus.resultReady  = 1'b1;

        // Reset state, with accelerateEn high to show inReady is still held low.
        repeat (3) @(negedge clk);
        check("rst_inReady", 32'(bus.inReady), 32'd0);
        check("rst_resultIsValid", 32'(bus.resultIsValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_macResult", 32'($unsigned(bus.macResult)), 32'd0);
        check("rst_resultChannel", 32'(bus.resultChannel), 32'd0);
        check("rst_resultPrimed", 32'(bus.resultPrimed), 32'd0);
        check("rst_coeffErr", 32'(coeffErr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_inReady", 32'(bus.inReady), 32'd1);

        // Coeffs 0.25; ch0 fed 1.0 and ch1 fed 3.0, interleaved.
        for (int k = 0; k < NT; k++) writeCoeff(3'(k), 16'h0040);
        for (int k = 1; k <= NT; k++) begin
            pushExp(1'b0, 16'(k * 'h40), k == NT);
            sendSample(1'b0, 16'h0100);
            pushExp(1'b1, 16'(k * 'hC0), k == NT);
            sendSample(1'b1, 16'h0300);
        end
        waitDrain();

        // Backpressure: result held for 5 cycles, latency measured.
        bus.resultReady = 1'b0;
        pushExp(1'b0, 16'h0200, 1'b1);
        sendSample(1'b0, 16'h0100);
        lat = 0;
        while (!bus.resultIsValid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency_cycles", 32'(lat), 32'(NT + 1));
        for (int i = 0; i < 5; i++) begin
            check("hold_macResult", 32'($unsigned(bus.macResult)), 32'h0200);
            check("hold_resultChannel", 32'(bus.resultChannel), 32'd0);
            check("hold_resultIsValid", 32'(bus.resultIsValid), 32'd1);
            check("hold_inReady", 32'(bus.inReady), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.resultReady = 1'b1;
        waitDrain();

        // Coefficient write during MAC is dropped; result uses old coeffs.
        pushExp(1'b0, 16'h0200, 1'b1);
        sendSample(1'b0, 16'h0100);
        coeffWriteEn = 1'b1;
        coeffAddress = 3'd0;
        coeffIn      = 16'h0100;
        @(posedge clk); #1;
        coeffWriteEn = 1'b0;
        @(negedge clk);
        check("coeffErr_pulse", 32'(coeffErr), 32'd1);
        @(negedge clk);
        check("coeffErr_clear", 32'(coeffErr), 32'd0);
        waitDrain();

        // Write and acceptance in the same cycle: write applies first.
        // accelerateEn drops while in flight; the sample still completes.
        pushExp(1'b0, 16'h02C0, 1'b1);
        @(posedge clk); #1;
        coeffWriteEn     = 1'b1;
        coeffAddress     = 3'd0;
        coeffIn          = 16'h0100;
        bus.inValid      = 1'b1;
        bus.inChannel    = 1'b0;
        bus.rawSensorVal = 16'h0100;
        @(negedge clk);
        check("same_cycle_inReady", 32'(bus.inReady), 32'd1);
        @(posedge clk); #1;
        coeffWriteEn = 1'b0;
        bus.inValid  = 1'b0;
        accelerateEn = 1'b0;
        @(negedge clk);
        check("idle_write_no_err", 32'(coeffErr), 32'd0);
        waitDrain();

        // accelerateEn low: offered sample is not taken.
        bus.inValid      = 1'b1;
        bus.inChannel    = 1'b1;
        bus.rawSensorVal = 16'h0100;
        repeat (3) begin
            @(negedge clk);
            check("accel_off_inReady", 32'(bus.inReady), 32'd0);
        end
        @(posedge clk); #1;
        bus.inValid  = 1'b0;
        accelerateEn = 1'b1;

        // clrC, then full-scale coeffs and samples on ch1.
        @(posedge clk); #1;
        clrC = 1'b1;
        @(posedge clk); #1;
        clrC = 1'b0;
        for (int k = 0; k < NT; k++) writeCoeff(3'(k), 16'h7FFF);
        for (int k = 1; k <= NT; k++) begin
`ifdef FIR_SATURATE_EN
            expVal = 16'h7FFF;
`else
            expVal = 16'(32'h10000 - k * 256);
`endif
            pushExp(1'b1, expVal, k == NT);
            sendSample(1'b1, 16'h7FFF);
        end
        waitDrain();

        // Reset mid-MAC: in-flight result is lost, outputs clear at once.
        sendSample(1'b0, 16'h0100);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_resultIsValid", 32'(bus.resultIsValid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_macResult", 32'($unsigned(bus.macResult)), 32'd0);
        check("rstmid_resultChannel", 32'(bus.resultChannel), 32'd0);
        check("rstmid_resultPrimed", 32'(bus.resultPrimed), 32'd0);
        check("rstmid_inReady", 32'(bus.inReady), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // clrC wins over a simultaneous sample offer.
        @(posedge clk); #1;
        clrC             = 1'b1;
        bus.inValid      = 1'b1;
        bus.inChannel    = 1'b0;
        bus.rawSensorVal = 16'h0300;
        @(negedge clk);
        check("clr_blocks_inReady", 32'(bus.inReady), 32'd0);
        @(posedge clk); #1;
        clrC        = 1'b0;
        bus.inValid = 1'b0;

        // Coeffs were reset; reload 0.25 and expect a partial sum, unprimed.
        for (int k = 0; k < NT; k++) writeCoeff(3'(k), 16'h0040);
        pushExp(1'b0, 16'h0080, 1'b0);
        sendSample(1'b0, 16'h0200);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
